cfg_crc_monitor: RTL and testbench

- Sequential scrubber for the 512-bit configuration image.
- Computes the 16-bit folded-XOR checksum of cfg_data one 16-bit word per cycle over 32 cycles:
  - result bit i = XOR of cfg_data[i+16k], k=0..31.
  - Reduces the combinational XOR tree to a 16-bit accumulator.
- Schedules scans on request, after config writes, and periodically.
- Latches a golden checksum on command and raises a sticky error on mismatch.
- Sits between the config register bank and the status/interrupt logic.

---
 rtl/cfg_crc_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_cfg_crc_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_crc_monitor.sv
// cfg_crc_monitor
// Sequential scrubber for the configuration image. One 16-bit word is folded
// into a 16-bit XOR accumulator per cycle, so a full pass over NWORDS words
// takes NWORDS cycles. Scans are started on request, after config writes,
// and periodically. A golden checksum can be locked on command, and later
// scans that disagree with it raise a sticky error flag.
// Optional build macro: CFG_CRC_IRQ_EN adds an irq output that pulses for one
// cycle on each rising edge of crc_err.
module cfg_crc_monitor #(
    parameter int NWORDS = 32,
    parameter int PER_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [16*NWORDS-1:0]  cfg_data,
    input  logic                  cfg_wr,
    input  logic                  scan_req,
    input  logic                  lock_req,
    input  logic                  err_clr,
    input  logic [PER_W-1:0]      period,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           crc_out,
    output logic                  crc_valid,
    output logic [15:0]           golden,
    output logic                  golden_valid,
    output logic                  crc_err
`ifdef CFG_CRC_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        acc_q, acc_d;
    logic [PER_W-1:0]   timer_q, timer_d;
    logic               pend_q, pend_d;
    logic               lock_pend_q, lock_pend_d;
    logic [15:0]        crc_out_q, crc_out_d;
    logic               crc_valid_q, crc_valid_d;
    logic [15:0]        golden_q, golden_d;
    logic               golden_valid_q, golden_valid_d;
    logic               crc_err_q, crc_err_d;
    logic               err_set;
    logic               trigger;

    // Split the flat image into addressable 16-bit words.
    logic [15:0] words [NWORDS];
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word
            assign words[gi] = cfg_data[16*gi +: 16];
        end
    endgenerate

    logic [15:0] word_sel;
    assign word_sel = words[idx_q];

    // A pending request, a write, an explicit request or an expired timer all start a scan.
    assign trigger = scan_req | cfg_wr | pend_q |
                     ((period != '0) && (timer_q == '0));

    // Next-state, datapath and status-flag logic for the scan sequencer.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        timer_d        = timer_q;
        pend_d         = pend_q;
        lock_pend_d    = lock_pend_q;
        crc_out_d      = crc_out_q;
        crc_valid_d    = crc_valid_q;
        golden_d       = golden_q;
        golden_valid_d = golden_valid_q;
        err_set        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        // Any write invalidates the last result, whatever the state.
        if (cfg_wr) begin
            crc_valid_d = 1'b0;
        end
        if (lock_req) begin
            lock_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - PER_W'(1);
                end
                if (trigger) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (scan_req) begin
                    pend_d = 1'b1;
                end
                if (cfg_wr) begin
                    // Image changed under us: restart the pass from word 0.
                    acc_d = '0;
                    idx_d = '0;
                end else begin
                    acc_d = acc_q ^ word_sel;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        crc_out_d   = acc_q ^ word_sel;
                        crc_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                timer_d = period;
                if (scan_req || cfg_wr) begin
                    pend_d = 1'b1;
                end
                if (lock_pend_q) begin
                    // A lock request seen in this cycle is kept for the next scan.
                    golden_d       = crc_out_q;
                    golden_valid_d = 1'b1;
                    lock_pend_d    = lock_req;
                end else if (golden_valid_q && (crc_out_q != golden_q)) begin
                    err_set = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new mismatch outranks a simultaneous clear.
        if (err_set) begin
            crc_err_d = 1'b1;
        end else if (err_clr) begin
            crc_err_d = 1'b0;
        end else begin
            crc_err_d = crc_err_q;
        end
    end

    // State and result registers; reset discards any partial scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            timer_q        <= '0;
            pend_q         <= 1'b0;
            lock_pend_q    <= 1'b0;
            crc_out_q      <= '0;
            crc_valid_q    <= 1'b0;
            golden_q       <= '0;
            golden_valid_q <= 1'b0;
            crc_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            timer_q        <= timer_d;
            pend_q         <= pend_d;
            lock_pend_q    <= lock_pend_d;
            crc_out_q      <= crc_out_d;
            crc_valid_q    <= crc_valid_d;
            golden_q       <= golden_d;
            golden_valid_q <= golden_valid_d;
            crc_err_q      <= crc_err_d;
        end
    end

    assign crc_out      = crc_out_q;
    assign crc_valid    = crc_valid_q;
    assign golden       = golden_q;
    assign golden_valid = golden_valid_q;
    assign crc_err      = crc_err_q;

`ifdef CFG_CRC_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = crc_err_d & ~crc_err_q;

    // One-cycle interrupt pulse aligned with crc_err rising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_cfg_crc_monitor.sv
// Self-checking bench for cfg_crc_monitor: directed scenarios plus random
// images, checked against a bit-level folded-XOR reference and a small
// golden/error model.
module tb_cfg_crc_monitor;

    localparam int NW = 32;
    localparam int PW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [16*NW-1:0] cfg_data;
    logic             cfg_wr, scan_req, lock_req, err_clr;
    logic [PW-1:0]    period;
    logic             busy, done, crc_valid, golden_valid, crc_err;
    logic [15:0]      crc_out, golden;
`ifdef CFG_CRC_IRQ_EN
    logic             irq;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model of the golden / error bookkeeping.
    logic [15:0] m_golden;
    logic        m_gv, m_err, m_lock;

    cfg_crc_monitor #(.NWORDS(NW), .PER_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_data     (cfg_data),
        .cfg_wr       (cfg_wr),
        .scan_req     (scan_req),
        .lock_req     (lock_req),
        .err_clr      (err_clr),
        .period       (period),
        .busy         (busy),
        .done         (done),
        .crc_out      (crc_out),
        .crc_valid    (crc_valid),
        .golden       (golden),
        .golden_valid (golden_valid),
        .crc_err      (crc_err)
`ifdef CFG_CRC_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    // Checksum bit i is the parity of every image bit whose index is i mod 16.
    function automatic logic [15:0] fold(input logic [16*NW-1:0] d);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 16*NW; b++) begin
            r[b % 16] = r[b % 16] ^ d[b];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"},         32'(busy),         32'd0);
        check({tag, " done"},         32'(done),         32'd0);
        check({tag, " crc_out"},      32'(crc_out),      32'd0);
        check({tag, " crc_valid"},    32'(crc_valid),    32'd0);
        check({tag, " golden"},       32'(golden),       32'd0);
        check({tag, " golden_valid"}, 32'(golden_valid), 32'd0);
        check({tag, " crc_err"},      32'(crc_err),      32'd0);
`ifdef CFG_CRC_IRQ_EN
        check({tag, " irq"},          32'(irq),          32'd0);
`endif
    endtask

    // Apply one completed scan result to the golden/error model.
    task automatic model_update(input logic [15:0] res, input bit clr);
        bit set;
        set = !m_lock && m_gv && (res != m_golden);
        if (m_lock) begin
            m_golden = res;
            m_gv     = 1'b1;
            m_lock   = 1'b0;
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    // Called in trigger cycle T with the trigger already driven; returns in T+34.
    task automatic scan_check(input string tag, input logic [15:0] exp, input bit clr_at_done);
        int nb, nd;
        nb = 0;
        nd = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            scan_req = 1'b0;
            cfg_wr   = 1'b0;
            lock_req = 1'b0;
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
        end
        check({tag, " busy cycles"}, 32'(nb), 32'd32);
        check({tag, " early done"},  32'(nd), 32'd0);
        tick();
        check({tag, " done"},      32'(done),      32'd1);
        check({tag, " busy@done"}, 32'(busy),      32'd0);
        check({tag, " crc_out"},   32'(crc_out),   32'(exp));
        check({tag, " crc_valid"}, 32'(crc_valid), 32'd1);
        err_clr = clr_at_done;
        model_update(exp, clr_at_done);
        tick();
        err_clr = 1'b0;
        check({tag, " crc_err"},      32'(crc_err),      32'(m_err));
        check({tag, " golden"},       32'(golden),       32'(m_golden));
        check({tag, " golden_valid"}, 32'(golden_valid), 32'(m_gv));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*NW-1:0] d;
        int cnt, nb, nd, nv;

        rst_n    = 1'b0;
        cfg_data = '0;
        cfg_wr   = 1'b0;
        scan_req = 1'b0;
        lock_req = 1'b0;
        err_clr  = 1'b0;
        period   = '0;
        m_golden = '0;
        m_gv     = 1'b0;
        m_err    = 1'b0;
        m_lock   = 1'b0;

        // Reset state.
        tick();
        tick();
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // All-zero image.
        scan_req = 1'b1;
        scan_check("zero", 16'h0000, 1'b0);

        // Bits 0, 16, 17 set: bit 0 cancels, bit 1 survives.
        cfg_data     = '0;
        cfg_data[0]  = 1'b1;
        cfg_data[16] = 1'b1;
        cfg_data[17] = 1'b1;
        scan_req     = 1'b1;
        scan_check("bits_0_16_17", 16'h0002, 1'b0);

        // Random images, triggered alternately by scan_req and cfg_wr.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 16*NW/32; w++) d[32*w +: 32] = $urandom();
            cfg_data = d;
            if (r % 2 == 1) cfg_wr = 1'b1;
            else scan_req = 1'b1;
            scan_check($sformatf("rand%0d", r), fold(d), 1'b0);
        end

        // Requests during a scan coalesce into exactly one follow-up scan.
        scan_req = 1'b1;
        nd = 0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            scan_req = (i == 5 || i == 20);
            if (i < 33 && done === 1'b1) nd++;
        end
        check("coal early done", 32'(nd), 32'd0);
        check("coal done", 32'(done), 32'd1);
        tick();
        tick();
        check("coal rescan busy", 32'(busy), 32'd1);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("coal rescan latency", 32'(cnt), 32'd32);
        check("coal rescan crc", 32'(crc_out), 32'(fold(cfg_data)));
        tick();
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy === 1'b1) nb++;
        end
        check("coal no third scan", 32'(nb), 32'd0);

        // Lock golden on all-ones image, then mismatch after flipping bit 5.
        cfg_data = '1;
        lock_req = 1'b1;
        scan_req = 1'b1;
        m_lock   = 1'b1;
        scan_check("lock_ones", 16'h0000, 1'b0);
        check("golden locked", 32'(golden), 32'h0000);
        check("golden_valid locked", 32'(golden_valid), 32'd1);
        cfg_data[5] = 1'b0;
        cfg_wr      = 1'b1;
        scan_check("flip5", 16'h0020, 1'b0);
        check("err after mismatch", 32'(crc_err), 32'd1);
`ifdef CFG_CRC_IRQ_EN
        check("irq pulse", 32'(irq), 32'd1);
        tick();
        check("irq one cycle", 32'(irq), 32'd0);
`endif
        // err_clr coincides with another mismatch: set wins.
        scan_req = 1'b1;
        scan_check("clr_vs_set", 16'h0020, 1'b1);
        check("err set wins", 32'(crc_err), 32'd1);
`ifdef CFG_CRC_IRQ_EN
        check("irq no repulse", 32'(irq), 32'd0);
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err   = 1'b0;
        check("err cleared", 32'(crc_err), 32'd0);

        // cfg_wr at scan cycle 10 restarts the pass.
        scan_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            scan_req = 1'b0;
        end
        for (int w = 0; w < 16*NW/32; w++) d[32*w +: 32] = $urandom();
        cfg_data = d;
        cfg_wr   = 1'b1;
        nb = 0;
        nd = 0;
        nv = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            cfg_wr = 1'b0;
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
            if (crc_valid !== 1'b0) nv++;
        end
        check("restart busy", 32'(nb), 32'd32);
        check("restart no done", 32'(nd), 32'd0);
        check("restart valid low", 32'(nv), 32'd0);
        tick();
        check("restart done", 32'(done), 32'd1);
        check("restart crc", 32'(crc_out), 32'(fold(d)));
        check("restart valid", 32'(crc_valid), 32'd1);
        model_update(fold(d), 1'b0);
        tick();
        check("restart crc_err", 32'(crc_err), 32'(m_err));

        // Periodic scans every period+34 cycles; period 0 disables them.
        period = 16'd100;
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("per first latency", 32'(cnt), 32'd33);
        check("per crc", 32'(crc_out), 32'(fold(cfg_data)));
        model_update(fold(cfg_data), 1'b0);
        tick();
        cnt = 1;
        while (done !== 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
        check("per spacing", 32'(cnt), 32'd134);
        model_update(fold(cfg_data), 1'b0);
        period = '0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
        end
        check("per off busy", 32'(nb), 32'd0);
        check("per off done", 32'(nd), 32'd0);
        check("per crc_err", 32'(crc_err), 32'(m_err));

        // Reset in the middle of a scan.
        scan_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            scan_req = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("midscan reset");
        m_golden = '0;
        m_gv     = 1'b0;
        m_err    = 1'b0;
        m_lock   = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
        end
        check("post reset busy", 32'(nb), 32'd0);
        check("post reset done", 32'(nd), 32'd0);

        // Fresh scan after reset still works.
        for (int w = 0; w < 16*NW/32; w++) d[32*w +: 32] = $urandom();
        cfg_data = d;
        scan_req = 1'b1;
        scan_check("after reset", fold(d), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
